// File: rtl/ysyx_22040365_ifu_pkg.sv
// ysyx_22040365_ifu_pkg
// Shared definitions for the instruction fetch unit: architectural widths,
// the default reset PC, fetch FSM state encodings, the FIFO entry layout and
// a PC alignment helper.
package ysyx_22040365_ifu_pkg;

  localparam int XLEN = 64;
  localparam int ILEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEF = 64'h8000_0000;

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DROP = 2'd3
  } ifu_state_e;

  // One buffered fetch: PC in the upper 64 bits, instruction in the lower 32.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] inst;
  } fetch_entry_t;

  localparam int ENTRY_W = XLEN + ILEN;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/ysyx_22040365_ifu_fifo.sv
// ysyx_22040365_ifu_fifo
// Synchronous instruction buffer with push, pop and flush. Flush wins over
// push/pop. Head data reads as zero while empty so the decode-side outputs
// are zero out of reset without resetting the storage array.
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   i_push      write i_wdata (caller guarantees not full)
//   i_wdata     entry to write
//   i_pop       retire head entry (ignored when empty)
//   i_flush     discard all entries
//   o_rdata     head entry (zero when empty)
//   o_count     number of valid entries
module ysyx_22040365_ifu_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 96
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  input  logic                     i_flush,
  output logic [WIDTH-1:0]         o_rdata,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push = i_push && (r_count != FULL);
  assign w_pop  = i_pop && (r_count != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is data only; validity is carried entirely by r_count.
  always_ff @(posedge clk) begin
    if (w_push && !i_flush) r_mem[r_wr] <= i_wdata;
  end

  assign o_rdata = (r_count != '0) ? r_mem[r_rd] : '0;
  assign o_count = r_count;

endmodule

// File: rtl/ysyx_22040365_ifu.sv
// ysyx_22040365_ifu
// Instruction fetch unit: owns the PC, keeps at most one fetch outstanding on
// the imem req/gnt/rvalid handshake, and buffers returned instructions in a
// small FIFO presented to decode with valid/ready. A redirect flushes the
// buffer and marks any in-flight fetch stale.
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   imem_req/imem_addr               fetch request and word-aligned address
//   imem_gnt                         request accepted this cycle
//   imem_rvalid/imem_rdata           fetch response
//   redirect_valid/redirect_pc       PC redirect strobe and target
//   inst_valid/inst/inst_pc          FIFO head towards decode
//   inst_ready                       decode consumes the head
module ysyx_22040365_ifu
  import ysyx_22040365_ifu_pkg::*;
#(
  parameter logic [63:0] RESET_PC   = RESET_PC_DEF,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [63:0] inst_pc,
  input  logic        inst_ready
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  ifu_state_e   r_state;
  logic [63:0]  r_pc;
  logic [63:0]  r_req_pc;
  logic [CW-1:0] w_count;
  fetch_entry_t w_head;
  fetch_entry_t w_push_entry;
  logic         w_grant;
  logic         w_resp;
  logic         w_push;
  logic         w_pop;

  // In REQ nothing is outstanding, so the credit check reduces to the
  // FIFO occupancy alone; a granted fetch always finds a free slot.
  assign imem_req  = (r_state == S_REQ) && (w_count < DEPTH_C);
  assign imem_addr = r_pc;

  assign w_grant = imem_req && imem_gnt;
  assign w_resp  = (r_state == S_WAIT) && imem_rvalid;
  assign w_push  = w_resp && !redirect_valid;
  assign w_pop   = inst_valid && inst_ready;

  assign w_push_entry = '{pc: r_req_pc, inst: imem_rdata};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_BOOT;
      r_pc    <= RESET_PC;
    end else begin
      case (r_state)
        S_BOOT: r_state <= S_REQ;
        S_REQ: begin
          // A grant coinciding with a redirect fetched the old stream.
          if (w_grant) r_state <= redirect_valid ? S_DROP : S_WAIT;
        end
        S_WAIT: begin
          if (imem_rvalid)         r_state <= S_REQ;
          else if (redirect_valid) r_state <= S_DROP;
        end
        S_DROP: begin
          if (imem_rvalid) r_state <= S_REQ;
        end
        default: r_state <= S_BOOT;
      endcase

      if (redirect_valid) r_pc <= align_pc(redirect_pc);
      else if (w_grant)   r_pc <= r_pc + 64'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (w_grant) r_req_pc <= r_pc;
  end

  ysyx_22040365_ifu_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_wdata (w_push_entry),
    .i_pop   (w_pop),
    .i_flush (redirect_valid),
    .o_rdata (w_head),
    .o_count (w_count)
  );

  assign inst_valid = (w_count != '0);
  assign inst       = w_head.inst;
  assign inst_pc    = w_head.pc;

endmodule

// File: tb/tb_ysyx_22040365_ifu.sv
module tb_ysyx_22040365_ifu;

  localparam int DEPTH = 2;
  localparam logic [63:0] RPC = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        inst_ready;

  ysyx_22040365_ifu #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: next fetch address, boot cycle, one outstanding fetch
  // (its address, remaining latency, whether a redirect made it stale) and
  // the queue of instructions decode must see, in order.
  logic [63:0] m_pc;
  bit          m_boot;
  bit          m_out;
  bit          m_stale;
  logic [63:0] m_oaddr;
  int          m_lat;
  logic [95:0] m_q[$];

  // Stimulus knobs
  int          p_gnt = 100;
  int          p_rdy = 100;
  int          p_redir = 0;
  int          lat_min = 0;
  int          lat_max = 0;
  bit          fixed_data = 1'b1;
  bit          f_redir = 1'b0;
  logic [63:0] f_target = '0;
  bit          f_stray = 1'b0;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = RPC;
    m_boot = 1'b1;
    m_out = 1'b0;
    m_stale = 1'b0;
    m_lat = 0;
    m_q.delete();
  endtask

  function automatic bit exp_req();
    return !m_boot && !m_out && (m_q.size() < DEPTH);
  endfunction

  task automatic compare();
    bit er;
    er = exp_req();
    chk("imem_req", imem_req, er);
    if (er) chk("imem_addr", imem_addr, m_pc);
    chk("inst_valid", inst_valid, m_q.size() != 0);
    if (m_q.size() != 0) chk("inst_head", {inst_pc, inst}, m_q[0]);
  endtask

  // Called at a falling edge: drive one cycle of inputs, advance the model
  // across the next rising edge, then compare at the following falling edge.
  task automatic tick();
    bit er, gr, rs, rd, rv;
    logic [63:0] tgt;
    logic [31:0] dat;
    er = exp_req();
    imem_gnt = (($urandom % 100) < p_gnt);
    rd = 1'b0;
    if (m_out) begin
      if (m_lat == 0) rd = 1'b1;
      else m_lat--;
    end
    if (f_stray) rd = 1'b1;
    f_stray = 1'b0;
    imem_rvalid = rd;
    dat = fixed_data ? 32'h0000_0013 : $urandom;
    imem_rdata = dat;
    inst_ready = (($urandom % 100) < p_rdy);
    rv = f_redir || (($urandom % 100) < p_redir);
    tgt = f_redir ? f_target : {$urandom, $urandom};
    f_redir = 1'b0;
    redirect_valid = rv;
    redirect_pc = tgt;

    gr = er && imem_gnt;
    rs = m_out && rd;
    if (rv) m_q.delete();
    else begin
      if (m_q.size() > 0 && inst_ready) void'(m_q.pop_front());
      if (rs && !m_stale) m_q.push_back({m_oaddr, dat});
    end
    if (gr) begin
      m_oaddr = m_pc;
      m_lat = $urandom_range(lat_max, lat_min);
      m_stale = rv;
      m_out = 1'b1;
    end else if (rs) begin
      m_out = 1'b0;
      m_stale = 1'b0;
    end else if (rv && m_out) begin
      m_stale = 1'b1;
    end
    if (rv)      m_pc = {tgt[63:2], 2'b00};
    else if (gr) m_pc = m_pc + 64'd4;
    m_boot = 1'b0;

    @(posedge clk);
    @(negedge clk);
    compare();
  endtask

  task automatic wait_req(input int budget);
    int k;
    k = 0;
    while (!imem_req && k < budget) begin
      tick();
      k++;
    end
    if (!imem_req) begin
      n_chk++;
      n_fail++;
      $display("FAIL wait_req: imem_req stayed %0b, expected 1 within %0d cycles", imem_req, budget);
    end
  endtask

  initial begin
    rst = 1'b1;
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = '0;
    redirect_valid = 0; redirect_pc = '0; inst_ready = 0;
    model_reset();
    @(negedge clk); @(negedge clk);
    chk("rst_req", imem_req, 1'b0);
    chk("rst_addr", imem_addr, 64'h8000_0000);
    chk("rst_valid", inst_valid, 1'b0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_inst_pc", inst_pc, 64'h0);
    rst = 1'b0;

    // Zero-wait memory, decode always ready
    tick();
    chk("zw_req0", imem_req, 1'b1);
    chk("zw_addr0", imem_addr, 64'h8000_0000);
    tick();
    chk("zw_wait_req", imem_req, 1'b0);
    chk("zw_valid_lo0", inst_valid, 1'b0);
    tick();
    chk("zw_valid_hi0", inst_valid, 1'b1);
    chk("zw_inst0", inst, 32'h0000_0013);
    chk("zw_pc0", inst_pc, 64'h8000_0000);
    chk("zw_addr1", imem_addr, 64'h8000_0004);
    tick();
    chk("zw_valid_lo1", inst_valid, 1'b0);
    tick();
    chk("zw_valid_hi1", inst_valid, 1'b1);
    chk("zw_pc1", inst_pc, 64'h8000_0004);
    chk("zw_addr2", imem_addr, 64'h8000_0008);

    // Decode stalled: buffer fills to exactly DEPTH and fetching stops
    p_rdy = 0;
    f_redir = 1'b1; f_target = 64'h8000_0000;
    for (int i = 0; i < 10; i++) tick();
    chk("hold_model_size", m_q.size(), 2);
    chk("hold_valid", inst_valid, 1'b1);
    chk("hold_req", imem_req, 1'b0);
    chk("hold_pc0", inst_pc, 64'h8000_0000);
    p_rdy = 100;
    tick();
    chk("hold_pc1", inst_pc, 64'h8000_0004);
    chk("hold_valid1", inst_valid, 1'b1);

    // Grant withheld: address must not move
    p_gnt = 0;
    for (int i = 0; i < 4; i++) tick();
    f_redir = 1'b1; f_target = 64'h8000_0000;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("nogt_req", imem_req, 1'b1);
      chk("nogt_addr", imem_addr, 64'h8000_0000);
      if (i < 2) tick();
    end
    p_gnt = 100; lat_min = 2; lat_max = 2;
    tick();
    chk("gnt_single", imem_req, 1'b0);

    // Redirect while waiting for data
    f_redir = 1'b1; f_target = 64'h8000_0103;
    tick();
    chk("rdw_empty", inst_valid, 1'b0);
    wait_req(10);
    chk("rdw_addr", imem_addr, 64'h8000_0100);
    chk("rdw_empty2", inst_valid, 1'b0);

    // Redirect coincident with grant (DROP path)
    lat_min = 0; lat_max = 0;
    f_redir = 1'b1; f_target = 64'h8000_2000;
    tick();
    chk("rdg_drop_req", imem_req, 1'b0);
    tick();
    chk("rdg_req", imem_req, 1'b1);
    chk("rdg_addr", imem_addr, 64'h8000_2000);
    chk("rdg_empty", inst_valid, 1'b0);
    // Redirect coincident with rvalid (direct REQ path)
    tick();
    f_redir = 1'b1; f_target = 64'h8000_3000;
    tick();
    chk("rdv_req", imem_req, 1'b1);
    chk("rdv_addr", imem_addr, 64'h8000_3000);
    chk("rdv_empty", inst_valid, 1'b0);

    // PC wrap modulo 2^64
    f_redir = 1'b1; f_target = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    wait_req(10);
    chk("wrap_addr0", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    tick();
    chk("wrap_addr1", imem_addr, 64'h0);
    chk("wrap_inst_pc", inst_pc, 64'hFFFF_FFFF_FFFF_FFFC);

    // Randomised traffic
    fixed_data = 1'b0;
    p_gnt = 60; p_rdy = 60; p_redir = 5; lat_min = 0; lat_max = 3;
    for (int i = 0; i < 3000; i++) tick();

    // Reset asserted mid-fetch, stray response after release
    p_redir = 0; p_gnt = 100; lat_min = 2; lat_max = 2;
    for (int i = 0; i < 20 && !m_out; i++) tick();
    chk("mid_outstanding", m_out, 1'b1);
    rst = 1'b1;
    imem_rvalid = 1'b0; redirect_valid = 1'b0;
    #1;
    chk("mr_req", imem_req, 1'b0);
    chk("mr_addr", imem_addr, 64'h8000_0000);
    chk("mr_valid", inst_valid, 1'b0);
    chk("mr_inst", inst, 32'h0);
    chk("mr_inst_pc", inst_pc, 64'h0);
    model_reset();
    @(posedge clk);
    imem_rvalid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    f_stray = 1'b1;
    tick();
    chk("mr_restart_req", imem_req, 1'b1);
    chk("mr_restart_addr", imem_addr, 64'h8000_0000);
    chk("mr_stray_ignored", inst_valid, 1'b0);
    lat_min = 0; lat_max = 1; p_rdy = 70;
    for (int i = 0; i < 40; i++) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
